// File: rtl/dpll_lock_detect_pkg.sv
// dpll_lock_detect_pkg: lock-state codes and shared defaults for the DPLL lock detector.
package dpll_lock_detect_pkg;

    localparam int ERR_W_DEF = 12;

    typedef enum logic [1:0] {
        LS_UNLOCKED  = 2'd0,
        LS_ACQUIRING = 2'd1,
        LS_LOCKED    = 2'd2,
        LS_HOLDOVER  = 2'd3
    } lock_state_e;

    function automatic logic is_locked(input lock_state_e s);
        return (s == LS_LOCKED) || (s == LS_HOLDOVER);
    endfunction

endpackage

// File: rtl/dpll_blink_gen.sv
// dpll_blink_gen: free-running divider whose output toggles every BLINK_DIV clock cycles.
module dpll_blink_gen #(
    parameter int BLINK_DIV = 1200000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic toggle_o
);

    localparam int DW = $clog2(BLINK_DIV) + 1;
    localparam logic [DW-1:0] LAST = DW'(BLINK_DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          tog_q, tog_d;

    assign cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    assign tog_d    = (cnt_q == LAST) ? ~tog_q : tog_q;
    assign toggle_o = tog_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
        end
    end

endmodule

// File: rtl/dpll_lock_detect.sv
// dpll_lock_detect: judges DPLL lock from phase-error samples; drives lock flag, lost pulse and LEDs.
module dpll_lock_detect
    import dpll_lock_detect_pkg::*;
#(
    parameter int ERR_W       = ERR_W_DEF,
    parameter int LOCK_WIN    = 8,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4,
    parameter int TIMEOUT_CYC = 24000,
    parameter int BLINK_DIV   = 1200000
) (
    input  logic             clk_12MHz,
    input  logic             reset,
    input  logic             err_valid,
    input  logic [ERR_W-1:0] phase_err,
    input  logic             dco_sat,
    output logic             locked,
    output logic [1:0]       lock_state,
    output logic             lock_lost,
    output logic [2:0]       leds
);

    localparam int GW = $clog2(LOCK_CNT) + 1;
    localparam int BW = $clog2(UNLOCK_CNT) + 1;
    localparam int IW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [ERR_W:0] WIN      = (ERR_W+1)'(LOCK_WIN);
    localparam logic [GW-1:0]  GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [BW-1:0]  BAD_MAX  = BW'(UNLOCK_CNT);
    localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT_CYC);
    localparam logic [IW-1:0]  IDLE_TO  = IW'(TIMEOUT_CYC - 1);

    lock_state_e    state_q, state_d;
    logic [GW-1:0]  good_q, good_d;
    logic [BW-1:0]  bad_q, bad_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic           lost_pulse_q, lost_pulse_d;
    logic           lost_led_q, lost_led_d;
    logic           blink;
    logic [ERR_W:0] err_ext, err_mag;
    logic           in_win, out_win, timeout;

    // One extra bit keeps the magnitude of the most negative sample representable.
    assign err_ext = {phase_err[ERR_W-1], phase_err};
    assign err_mag = phase_err[ERR_W-1] ? -err_ext : err_ext;
    assign in_win  = err_valid & (err_mag <= WIN);
    assign out_win = err_valid & ~in_win;
    assign timeout = (idle_q == IDLE_TO) & ~err_valid;

    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        bad_d        = bad_q;
        idle_d       = err_valid ? '0 : (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
        lost_pulse_d = 1'b0;
        case (state_q)
            LS_UNLOCKED: begin
                if (!dco_sat && in_win) state_d = LS_ACQUIRING;
            end
            LS_ACQUIRING: begin
                if (dco_sat || out_win || timeout) state_d = LS_UNLOCKED;
                else if (in_win) begin
                    good_d = good_q + 1'b1;
                    if (good_d == GOOD_MAX) state_d = LS_LOCKED;
                end
            end
            LS_LOCKED: begin
                if (dco_sat) state_d = LS_UNLOCKED;
                else if (out_win) begin
                    bad_d = bad_q + 1'b1;
                    if (bad_d == BAD_MAX) state_d = LS_UNLOCKED;
                end else if (in_win) bad_d = '0;
                else if (timeout) begin
                    state_d = LS_HOLDOVER;
                    idle_d  = '0;
                end
            end
            LS_HOLDOVER: begin
                if (dco_sat || out_win || timeout) state_d = LS_UNLOCKED;
                else if (in_win) state_d = LS_LOCKED;
            end
        endcase
        // Every state change clears both run counters; entering ACQUIRING already counts one good sample.
        if (state_d != state_q) begin
            good_d = (state_d == LS_ACQUIRING) ? GW'(1) : '0;
            bad_d  = '0;
        end
        lost_pulse_d = is_locked(state_q) && (state_d == LS_UNLOCKED);
        lost_led_d   = lost_pulse_d ? 1'b1
                     : (state_q == LS_ACQUIRING && state_d == LS_LOCKED) ? 1'b0 : lost_led_q;
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q      <= LS_UNLOCKED;
            good_q       <= '0;
            bad_q        <= '0;
            idle_q       <= '0;
            lost_pulse_q <= 1'b0;
            lost_led_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            idle_q       <= idle_d;
            lost_pulse_q <= lost_pulse_d;
            lost_led_q   <= lost_led_d;
        end
    end

    dpll_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clk_i    (clk_12MHz),
        .rst_i    (reset),
        .toggle_o (blink)
    );

    assign locked     = is_locked(state_q);
    assign lock_state = state_q;
    assign lock_lost  = lost_pulse_q;
    assign leds       = {lost_led_q,
                         (state_q == LS_ACQUIRING) ? blink : (state_q == LS_HOLDOVER),
                         is_locked(state_q)};

endmodule
